des_stream: RTL and testbench
=============================

// Module: des_stream
// PURPOSE
//  Parametrised N-to-M deserializer with valid/ready output handshake, start-of-frame
//  word alignment, selectable beat order, and overrun/misalign error reporting.
//  Sits behind a serial/narrow receive front-end. Packs K=M/N input beats into one M-bit
//  word and hands it to a downstream consumer that may stall.
// PARAMETERS
//  N          1   input beat width in bits (>=1)
//  M          8   output word width in bits; M % N == 0 required (elaboration $error otherwise)
//  LSB_FIRST  1   1: first beat of a word -> out_data[N-1:0]; 0: first beat -> out_data[M-1:M-N]
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    reset, asynchronous, active-high
//  in_valid   in   1    in_data carries a beat this cycle (no input backpressure)
//  in_sof     in   1    qualified by in_valid: this beat is beat 0 of a new word
//  in_data    in   N    input beat
//  out_valid  out  1    out_data holds a complete word
//  out_ready  in   1    consumer accepts word when out_valid&&out_ready
//  out_data   out  M    assembled word, stable while out_valid&&!out_ready
//  beat_idx   out  W    beats collected toward the current word, 0..K-1; W=max(1,$clog2(K))
//  overrun    out  1    1-cycle pulse: completed word dropped, holding register still full
//  misalign   out  1    1-cycle pulse: in_sof arrived with beat_idx!=0, partial word discarded
// BEHAVIOUR
//  Reset (async): beat_idx=0, shift reg=0, out_valid=0, out_data=0, overrun=0, misalign=0.
//  Beat accept: every cycle with in_valid=1. Idle cycles (in_valid=0) hold all state.
//  Assembly: beat j (0..K-1) lands at bits [j*N +: N] (LSB_FIRST=1)
//   or [(K-1-j)*N +: N] (LSB_FIRST=0). beat_idx increments per beat and wraps K-1 -> 0.
//  SOF: in_valid&&in_sof forces the beat to slot 0 and sets beat_idx=1 (0 if K==1).
//   If beat_idx!=0 at that time, the partial word is discarded and misalign pulses next cycle.
//   SOF with beat_idx==0 is a normal beat with no error.
//  Completion: the beat taken with beat_idx==K-1 (or SOF beat when K==1) completes the word.
//  Holding register: a completed word loads out_data on the same edge if the register is
//   empty, or is freed this cycle (out_valid&&out_ready). out_valid=1 from the next cycle.
//   Latency: last beat at edge t -> out_valid/out_data visible after edge t.
//  Full, no consume: the completed word is dropped. Held word unchanged. overrun pulses
//   next cycle. Assembly restarts at beat_idx=0.
//  Simultaneous complete + out_ready while full: new word replaces old, out_valid stays 1,
//   no overrun (back-to-back at 1 word/K beats, or 1 word/cycle when K==1).
//  out_valid&&out_ready without completion: out_valid->0. out_data keeps its last value.
//  Simultaneous SOF misalign and completion are impossible (SOF resets to slot 0).
//   When K==1, SOF never flags misalign.
//  Reset mid-word or mid-handshake: partial and held words are lost immediately.
//   No output pulse.
//  Unused bits none. Counter compares against K-1 as a W-bit constant. No arithmetic overflow.
// TESTING  (default N=2,M=8 unless noted; K=4)
//  1 beats 2'b01,2'b10,2'b11,2'b00 (SOF on first), out_ready=1 -> out_data=8'h39,
//    out_valid 1 cycle after 4th beat
//  2 same beats, LSB_FIRST=0 -> out_data=8'h6C. N=1,M=8 bits 1,0,1,1,0,0,0,0 LSB_FIRST=1
//    -> 8'h0D
//  3 out_ready=0, two full words 8'hA5 then 8'h3C -> out_data stays 8'hA5, overrun pulses once
//    after 8th beat. Then out_ready=1 -> handshake, out_valid=0
//  4 two beats then SOF beat -> misalign pulses 1 cycle, beat_idx=1. Next 3 beats form a word
//    from the SOF beat
//  5 continuous beats, out_ready held 1 -> one word every 4 cycles, no overrun. Toggle in_valid
//    randomly -> same words, gaps ignored
//  6 assert rst async mid-word (beat_idx=2) and with out_valid=1 -> all outputs 0 immediately.
//    Next SOF word assembles correctly

Source files
------------

// File: rtl/des_stream.sv
// N-to-M stream deserializer: packs K=M/N beats into one word with SOF alignment,
// selectable beat order, a single-entry valid/ready holding register and error pulses.
module des_stream #(
  parameter int N         = 1,
  parameter int M         = 8,
  parameter int LSB_FIRST = 1,
  localparam int K        = M / N,
  localparam int W        = (K > 1) ? $clog2(K) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic [W-1:0] beat_idx,
  output logic         overrun,
  output logic         misalign
);

  if (N < 1 || (M % N) != 0) begin : g_bad_cfg
    $error("des_stream: M must be a non-zero multiple of N");
  end

  localparam logic [W-1:0] LAST = W'(K - 1);

  logic [K-1:0][N-1:0] shreg;
  logic [K-1:0][N-1:0] word;
  logic [W-1:0]        slot;
  logic                complete;
  logic                take;
  logic                consume;

  // SOF restarts the word at beat 0 regardless of where the counter was
  assign slot     = in_sof ? '0 : beat_idx;
  assign complete = in_valid && (slot == LAST);
  assign consume  = out_valid && out_ready;
  assign take     = !out_valid || out_ready;

  // Physical slot p receives logical beat J; SOF clears leftovers of a discarded word
  for (genvar p = 0; p < K; p++) begin : g_slot
    localparam int J = (LSB_FIRST != 0) ? p : (K - 1 - p);
    assign word[p] = (slot == W'(J)) ? in_data : (in_sof ? '0 : shreg[p]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx  <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      misalign <= 1'b0;
      if (in_valid) begin
        beat_idx <= complete ? '0 : slot + 1'b1;
        shreg    <= complete ? '0 : word;
        misalign <= in_sof && (beat_idx != '0);
      end
      if (complete && take) begin
        out_valid <= 1'b1;
        out_data  <= word;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_stream.sv
// Self-checking bench for des_stream: four configurations driven in parallel, checked
// against a queue-based word model plus directed vector tables.
module tb_des_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] rd = 8'h00;

  logic       ov0, ov1, ov2, ov3;
  logic [7:0] od0, od1, od2, od3;
  logic [1:0] bi0, bi1;
  logic [2:0] bi2;
  logic       bi3;
  logic       or0, or1, or2, or3;
  logic       mi0, mi1, mi2, mi3;

  des_stream #(.N(2), .M(8), .LSB_FIRST(1)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(rd[1:0]), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .beat_idx(bi0), .overrun(or0), .misalign(mi0));
  des_stream #(.N(2), .M(8), .LSB_FIRST(0)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(rd[1:0]), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .beat_idx(bi1), .overrun(or1), .misalign(mi1));
  des_stream #(.N(1), .M(8), .LSB_FIRST(1)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(rd[0]), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .beat_idx(bi2), .overrun(or2), .misalign(mi2));
  des_stream #(.N(8), .M(8), .LSB_FIRST(1)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_sof(in_sof), .in_data(rd), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .beat_idx(bi3), .overrun(or3), .misalign(mi3));

  logic       a_vld[4];
  logic [7:0] a_dat[4];
  logic [2:0] a_idx[4];
  logic       a_ovr[4];
  logic       a_mis[4];
  assign a_vld[0] = ov0;  assign a_vld[1] = ov1;  assign a_vld[2] = ov2;  assign a_vld[3] = ov3;
  assign a_dat[0] = od0;  assign a_dat[1] = od1;  assign a_dat[2] = od2;  assign a_dat[3] = od3;
  assign a_idx[0] = {1'b0, bi0};  assign a_idx[1] = {1'b0, bi1};
  assign a_idx[2] = bi2;          assign a_idx[3] = {2'b00, bi3};
  assign a_ovr[0] = or0;  assign a_ovr[1] = or1;  assign a_ovr[2] = or2;  assign a_ovr[3] = or3;
  assign a_mis[0] = mi0;  assign a_mis[1] = mi1;  assign a_mis[2] = mi2;  assign a_mis[3] = mi3;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  // Reference model: beats collected in a queue, word built when K beats are present
  int PN[4] = '{2, 2, 1, 8};
  int PL[4] = '{1, 0, 1, 1};
  int mq[4][$];
  int m_vld[4], m_dat[4], m_ovr[4], m_mis[4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_vld[i] = 0; m_dat[i] = 0; m_ovr[i] = 0; m_mis[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int k, w, pos;
      bit cons, done;
      k = 8 / PN[i];
      w = 0;
      done = 0;
      cons = (m_vld[i] != 0) && out_ready;
      m_ovr[i] = 0;
      m_mis[i] = 0;
      if (in_valid) begin
        if (in_sof) begin
          if (mq[i].size() != 0) m_mis[i] = 1;
          mq[i].delete();
        end
        mq[i].push_back(int'(rd) & ((1 << PN[i]) - 1));
        if (mq[i].size() == k) begin
          for (int j = 0; j < k; j++) begin
            pos = (PL[i] != 0) ? j : (k - 1 - j);
            w |= mq[i][j] << (pos * PN[i]);
          end
          mq[i].delete();
          done = 1;
        end
      end
      if (done) begin
        if (m_vld[i] == 0 || cons) begin
          m_dat[i] = w;
          m_vld[i] = 1;
        end else m_ovr[i] = 1;
      end else if (cons) m_vld[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      chk("model_valid", i, 32'(a_vld[i]), 32'(m_vld[i]));
      chk("model_data", i, 32'(a_dat[i]), 32'(m_dat[i]));
      chk("model_idx", i, 32'(a_idx[i]), 32'(mq[i].size()));
      chk("model_overrun", i, 32'(a_ovr[i]), 32'(m_ovr[i]));
      chk("model_misalign", i, 32'(a_mis[i]), 32'(m_mis[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic r);
    in_valid = v; in_sof = s; rd = d; out_ready = r;
  endtask

  task automatic chk_zero(input string nm);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_valid"}, i, 32'(a_vld[i]), 0);
      chk({nm, "_data"}, i, 32'(a_dat[i]), 0);
      chk({nm, "_idx"}, i, 32'(a_idx[i]), 0);
      chk({nm, "_ovr"}, i, 32'(a_ovr[i]), 0);
      chk({nm, "_mis"}, i, 32'(a_mis[i]), 0);
    end
  endtask

  typedef struct {
    logic       v, s;
    logic [1:0] d;
    logic       r, ev;
    logic [7:0] ed0, ed1;
    logic [1:0] ei;
    logic       eov, emis;
  } vec_t;

  function automatic vec_t mk(logic v, logic s, logic [1:0] d, logic r, logic ev,
                              logic [7:0] ed0, logic [7:0] ed1, logic [1:0] ei,
                              logic eov, logic emis);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r = r; t.ev = ev;
    t.ed0 = ed0; t.ed1 = ed1; t.ei = ei; t.eov = eov; t.emis = emis;
    return t;
  endfunction

  vec_t tbl[22];
  logic [7:0] nbits;

  initial begin
    // basic word, LSB/MSB order
    tbl[0]  = mk(1, 1, 2'd1, 1, 0, 8'h00, 8'h00, 2'd1, 0, 0);
    tbl[1]  = mk(1, 0, 2'd2, 1, 0, 8'h00, 8'h00, 2'd2, 0, 0);
    tbl[2]  = mk(1, 0, 2'd3, 1, 0, 8'h00, 8'h00, 2'd3, 0, 0);
    tbl[3]  = mk(1, 0, 2'd0, 1, 1, 8'h39, 8'h6C, 2'd0, 0, 0);
    tbl[4]  = mk(0, 0, 2'd0, 1, 0, 8'h39, 8'h6C, 2'd0, 0, 0);
    // stalled consumer: second word dropped with overrun
    tbl[5]  = mk(1, 1, 2'd1, 0, 0, 8'h39, 8'h6C, 2'd1, 0, 0);
    tbl[6]  = mk(1, 0, 2'd1, 0, 0, 8'h39, 8'h6C, 2'd2, 0, 0);
    tbl[7]  = mk(1, 0, 2'd2, 0, 0, 8'h39, 8'h6C, 2'd3, 0, 0);
    tbl[8]  = mk(1, 0, 2'd2, 0, 1, 8'hA5, 8'h5A, 2'd0, 0, 0);
    tbl[9]  = mk(1, 1, 2'd0, 0, 1, 8'hA5, 8'h5A, 2'd1, 0, 0);
    tbl[10] = mk(1, 0, 2'd3, 0, 1, 8'hA5, 8'h5A, 2'd2, 0, 0);
    tbl[11] = mk(1, 0, 2'd3, 0, 1, 8'hA5, 8'h5A, 2'd3, 0, 0);
    tbl[12] = mk(1, 0, 2'd0, 0, 1, 8'hA5, 8'h5A, 2'd0, 1, 0);
    tbl[13] = mk(0, 0, 2'd0, 0, 1, 8'hA5, 8'h5A, 2'd0, 0, 0);
    tbl[14] = mk(0, 0, 2'd0, 1, 0, 8'hA5, 8'h5A, 2'd0, 0, 0);
    // SOF mid-word: misalign, new word starts from the SOF beat
    tbl[15] = mk(1, 1, 2'd1, 1, 0, 8'hA5, 8'h5A, 2'd1, 0, 0);
    tbl[16] = mk(1, 0, 2'd2, 1, 0, 8'hA5, 8'h5A, 2'd2, 0, 0);
    tbl[17] = mk(1, 1, 2'd3, 1, 0, 8'hA5, 8'h5A, 2'd1, 0, 1);
    tbl[18] = mk(1, 0, 2'd0, 1, 0, 8'hA5, 8'h5A, 2'd2, 0, 0);
    tbl[19] = mk(1, 0, 2'd1, 1, 0, 8'hA5, 8'h5A, 2'd3, 0, 0);
    tbl[20] = mk(1, 0, 2'd2, 1, 1, 8'h93, 8'hC6, 2'd0, 0, 0);
    tbl[21] = mk(0, 0, 2'd0, 1, 0, 8'h93, 8'hC6, 2'd0, 0, 0);

    model_reset();
    #12;
    chk_zero("reset");
    rst = 1'b0;

    for (int n = 0; n < 22; n++) begin
      drive(tbl[n].v, tbl[n].s, {6'b0, tbl[n].d}, tbl[n].r);
      tick();
      chk("tbl_valid", n, 32'(ov0), 32'(tbl[n].ev));
      chk("tbl_data0", n, 32'(od0), 32'(tbl[n].ed0));
      chk("tbl_data1", n, 32'(od1), 32'(tbl[n].ed1));
      chk("tbl_idx", n, 32'(bi0), 32'(tbl[n].ei));
      chk("tbl_overrun", n, 32'(or0), 32'(tbl[n].eov));
      chk("tbl_misalign", n, 32'(mi0), 32'(tbl[n].emis));
    end

    // N=1: bits 1,0,1,1,0,0,0,0 -> 8'h0D
    nbits = 8'b0000_1101;
    for (int b = 0; b < 8; b++) begin
      drive(1, b == 0, {7'b0, nbits[b]}, 1);
      tick();
    end
    chk("n1_valid", 2, 32'(ov2), 1);
    chk("n1_data", 2, 32'(od2), 32'h0D);

    // async reset with a held word and a half-built word
    for (int b = 0; b < 4; b++) begin
      drive(1, b == 0, 8'(b + 1), 0);
      tick();
    end
    drive(1, 1, 8'd1, 0); tick();
    drive(1, 0, 8'd2, 0); tick();
    chk("pre_rst_idx", 0, 32'(bi0), 2);
    chk("pre_rst_valid", 0, 32'(ov0), 1);
    drive(0, 0, 8'd0, 0);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    drive(1, 1, 8'd1, 1); tick();
    drive(1, 0, 8'd2, 1); tick();
    drive(1, 0, 8'd3, 1); tick();
    drive(1, 0, 8'd0, 1); tick();
    chk("post_rst_data", 0, 32'(od0), 32'h39);
    chk("post_rst_valid", 0, 32'(ov0), 1);

    // continuous beats, consumer always ready
    for (int c = 0; c < 16; c++) begin
      drive(1, c == 0, 8'($urandom), 1);
      tick();
    end

    // random traffic with stalls and stray SOFs
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 8'($urandom), 1'($urandom));
      tick();
    end

    // random gaps, consumer always ready
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom), $urandom_range(0, 15) == 0, 8'($urandom), 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
